// File: rtl/adder_arb_pkg.sv
// Shared constants and pipeline record types for the adder_slot_arbiter block.
// Used by the top level, the round-robin picker and the adder core.
package adder_arb_pkg;

  localparam int WIDTH = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Issue-stage record: operation and raw operands of the granted slot.
  typedef struct packed {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_rec_t;

  // Response-stage record: adder result.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } s2_rec_t;

endpackage

// File: rtl/adder_slot_arbiter_cla.sv
// 64-bit two-level carry-lookahead adder: 4-bit lookahead groups chained by
// group generate/propagate.
module adder_arb_cla
  import adder_arb_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GRP  = 4;
  localparam int NGRP = WIDTH / GRP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gp;
  logic [NGRP:0]    gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path leaves
    // a bit unassigned and no latch can be inferred.
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < NGRP; k++) begin
      gg[k] = g[GRP*k+3]
            | (p[GRP*k+3] & g[GRP*k+2])
            | (p[GRP*k+3] & p[GRP*k+2] & g[GRP*k+1])
            | (p[GRP*k+3] & p[GRP*k+2] & p[GRP*k+1] & g[GRP*k]);
      gp[k] = &p[GRP*k +: GRP];
    end
    gc[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Per-bit carries inside each group are expanded from the group carry-in.
    for (int k = 0; k < NGRP; k++) begin
      c[GRP*k]   = gc[k];
      c[GRP*k+1] = g[GRP*k] | (p[GRP*k] & gc[k]);
      c[GRP*k+2] = g[GRP*k+1] | (p[GRP*k+1] & g[GRP*k])
                 | (p[GRP*k+1] & p[GRP*k] & gc[k]);
      c[GRP*k+3] = g[GRP*k+2] | (p[GRP*k+2] & g[GRP*k+1])
                 | (p[GRP*k+2] & p[GRP*k+1] & g[GRP*k])
                 | (p[GRP*k+2] & p[GRP*k+1] & p[GRP*k] & gc[k]);
    end
    c[WIDTH] = gc[NGRP];
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/adder_slot_arbiter_rr_pick.sv
// Round-robin picker: grants the first requester at ptr, ptr+1, ... (mod NREQ)
// while enabled; returns a one-hot grant and its encoded index.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    gnt = '0;
    idx = '0;
    // Scan from the farthest offset back to ptr so the closest requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % NREQ]) begin
        gnt                           = '0;
        gnt[(int'(ptr) + k) % NREQ]   = 1'b1;
        idx                           = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/adder_slot_arbiter.sv
// Round-robin sharing of one 64-bit CLA among NREQ issue slots, 2-stage pipeline.
// Define ADD_ARB_OVF_EN to register signed overflow alongside the result.
module adder_slot_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0] opa,
  input  logic [NREQ*WIDTH-1:0] opb,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   s1_id;
  logic [IDW-1:0]   s2_id;
  logic             s1_valid;
  s1_rec_t          s1;
  s2_rec_t          s2;
  logic             s2_adv;
  logic             s1_adv;
  logic             s1_free;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign s2_adv  = !rsp_valid || rsp_ready;
  assign s1_adv  = s1_valid && s2_adv;
  assign s1_free = !s1_valid || s2_adv;

  // Gating with rst_n keeps gnt low for the whole reset window.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .en  (s1_free && rst_n),
    .gnt (gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so the S1 load and the S1->S2 transfer in one cycle cannot race.
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1       <= '0;
    end else begin
      if (|gnt) begin
        s1_valid <= 1'b1;
        s1_id    <= pick_idx;
        s1       <= '{op: op[pick_idx],
                      a:  opa[int'(pick_idx)*WIDTH +: WIDTH],
                      b:  opb[int'(pick_idx)*WIDTH +: WIDTH]};
        ptr      <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Subtraction is a + ~b + 1 through the same core.
  assign in2 = (s1.op == OP_SUB) ? ~s1.b : s1.b;
  assign cin = (s1.op != OP_ADD);

  adder_arb_cla u_cla (
    .a    (s1.a),
    .b    (in2),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      s2_id     <= '0;
      s2        <= '0;
    end else if (s1_adv) begin
      rsp_valid <= 1'b1;
      s2_id     <= s1_id;
      s2        <= '{sum: sum, cout: cout};
    end else if (s2_adv) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADD_ARB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (s1_adv) begin
      ovf_q <= (s1.a[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != s1.a[WIDTH-1]);
    end
  end

  assign rsp_ovf = ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  assign rsp_id   = s2_id;
  assign rsp_sum  = s2.sum;
  assign rsp_cout = s2.cout;
  assign busy     = s1_valid || rsp_valid;

endmodule

// File: tb/tb_adder_slot_arbiter.sv
// Scoreboard bench for adder_slot_arbiter: randomized slot traffic against an
// arithmetic reference model, with occupancy-based grant and latency prediction.
module tb_adder_slot_arbiter;
  import adder_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       op;
  logic [NREQ*WIDTH-1:0] opa;
  logic [NREQ*WIDTH-1:0] opb;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;
  logic                  busy;

  adder_slot_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ptr = 0;
  int   cyc = 0;

  logic [NREQ-1:0] s_req;
  logic [NREQ-1:0] s_op;
  logic [63:0]     s_a [NREQ];
  logic [63:0]     s_b [NREQ];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 65-bit unsigned and signed values.
  function automatic exp_t predict(input int id, input logic o, input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic        [64:0] full;
    logic signed [64:0] sres;
    e.id   = id;
    e.gcyc = 0;
    if (o == OP_ADD) begin
      full   = {1'b0, a} + {1'b0, b};
      e.cout = full[64];
      sres   = $signed({a[63], a}) + $signed({b[63], b});
    end else begin
      full   = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
      sres   = $signed({a[63], a}) - $signed({b[63], b});
    end
    e.sum = full[63:0];
`ifdef ADD_ARB_OVF_EN
    e.ovf = (sres[64] != sres[63]);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: predicts grant from occupancy and rotation, checks responses in order.
  always @(negedge clk) begin
    int              n;
    int              eg_idx;
    logic [NREQ-1:0] eg;
    exp_t            e;
    cyc++;
    if (!rst_n) begin
      check("gnt_in_reset", gnt, '0);
      check("rsp_valid_in_reset", rsp_valid, 1'b0);
      check("busy_in_reset", busy, 1'b0);
      sb.delete();
      model_ptr = 0;
    end else begin
      n = sb.size();
      check("busy", busy, n != 0);
      check("rsp_valid", rsp_valid, (n != 0) && ((cyc - sb[0].gcyc) >= 2));
      if (rsp_valid && n != 0) begin
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_sum", rsp_sum, sb[0].sum);
        check("rsp_cout", rsp_cout, sb[0].cout);
        check("rsp_ovf", rsp_ovf, sb[0].ovf);
        if (rsp_ready) void'(sb.pop_front());
      end
      // Two ops in flight fill both stages; a third is accepted only as one drains.
      eg_idx = -1;
      if (req != '0 && (n < 2 || rsp_ready)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (eg_idx < 0 && req[(model_ptr + k) % NREQ]) eg_idx = (model_ptr + k) % NREQ;
        end
      end
      eg = '0;
      if (eg_idx >= 0) eg[eg_idx] = 1'b1;
      check("gnt", gnt, eg);
      if (eg_idx >= 0) begin
        e      = predict(eg_idx, op[eg_idx], opa[eg_idx*WIDTH +: WIDTH], opb[eg_idx*WIDTH +: WIDTH]);
        e.gcyc = cyc;
        sb.push_back(e);
        glog.push_back(eg_idx);
        model_ptr = (eg_idx + 1) % NREQ;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_proto
    assert property (@(posedge clk) disable iff (!rst_n)
      (req[i] && !gnt[i]) |=> (req[i] && $stable(op[i]) &&
                               $stable(opa[i*WIDTH +: WIDTH]) && $stable(opb[i*WIDTH +: WIDTH])));
  end

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0;
      4:       return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic apply();
    req = s_req;
    op  = s_op;
    for (int i = 0; i < NREQ; i++) begin
      opa[i*WIDTH +: WIDTH] = s_a[i];
      opb[i*WIDTH +: WIDTH] = s_b[i];
    end
  endtask

  task automatic set_slot(input int i, input logic o, input logic [63:0] a, input logic [63:0] b);
    s_req[i] = 1'b1;
    s_op[i]  = o;
    s_a[i]   = a;
    s_b[i]   = b;
  endtask

  // One cycle: note grants at negedge, retire them after the edge, refill idle slots.
  task automatic step(input int p_new, input logic rdy);
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = gnt & req;
    @(posedge clk);
    #1;
    s_req = s_req & ~g;
    for (int i = 0; i < NREQ; i++) begin
      if (!s_req[i] && $urandom_range(0, 99) < p_new)
        set_slot(i, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
    end
    rsp_ready = rdy;
    apply();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((s_req != '0 || sb.size() != 0) && k < budget) begin
      step(0, 1'b1);
      k++;
    end
    if (s_req != '0 || sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending req %b, outstanding %0d after %0d cycles", s_req, sb.size(), budget);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    s_req = '0;
    apply();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int exp_order[6];
    int k;
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    s_req     = '0;
    s_op      = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_a[i] = '0;
      s_b[i] = '0;
    end
    apply();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed arithmetic corners.
    set_slot(0, OP_ADD, 64'd5, 64'd7);                      apply(); drain(20);
    set_slot(2, OP_SUB, 64'd5, 64'd3);                      apply(); drain(20);
    set_slot(2, OP_SUB, 64'd3, 64'd5);                      apply(); drain(20);
    set_slot(1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);    apply(); drain(20);
    set_slot(3, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);    apply(); drain(20);
    set_slot(1, OP_SUB, 64'h8000_0000_0000_0000, 64'd1);    apply(); drain(20);

    // All slots requesting from a fresh pointer: strict rotation.
    pulse_reset();
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_slot(i, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
    apply();
    repeat (6) step(100, 1'b1);
    check("rr_grant_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) check("rr_order", glog[i], exp_order[i]);

    // Backpressure in the middle of a full-rate stream.
    repeat (3) step(100, 1'b0);
    repeat (4) step(100, 1'b1);
    drain(50);

    // Random traffic and random backpressure.
    repeat (1500) step(40, $urandom_range(0, 9) < 7);
    drain(100);

    // Reset with both stages occupied.
    set_slot(0, OP_ADD, rand_opnd(), rand_opnd());
    set_slot(2, OP_SUB, rand_opnd(), rand_opnd());
    rsp_ready = 1'b0;
    apply();
    k = 0;
    while (s_req != '0 && k < 10) begin
      step(0, 1'b0);
      k++;
    end
    check("two_in_flight", sb.size(), 2);
    check("busy_before_rst", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rsp_valid_on_rst", rsp_valid, 1'b0);
    check("busy_on_rst", busy, 1'b0);
    check("gnt_on_rst", gnt, '0);
    s_req = '0;
    apply();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    glog.delete();
    set_slot(3, OP_ADD, rand_opnd(), rand_opnd());
    set_slot(1, OP_SUB, rand_opnd(), rand_opnd());
    rsp_ready = 1'b1;
    apply();
    step(0, 1'b1);
    check("first_grant_after_rst_count", glog.size(), 1);
    if (glog.size() > 0) check("first_grant_after_rst", glog[0], 1);
    drain(20);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
